// File: rtl/spi_counter_sequencer.sv
// Run/stop decimal counter that streams each new value to the SPI byte engine as a {hi, lo} frame.
// Latency: a pending value reaches o_start two cycles after IDLE sees it; each byte waits for i_done without a timeout.
module spi_counter_sequencer #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int COUNT_MAX = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run_stop,
    input  logic        i_clear,
    input  logic        i_done,
    output logic        o_start,
    output logic [7:0]  o_tx_data,
    output logic        o_ss_n,
    output logic [13:0] o_count,
    output logic        o_running
);

    localparam int              TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [13:0]     CNT_LAST  = 14'(COUNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SS_SETUP,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        SS_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            running;
    logic [TW-1:0]   tick_cnt;
    logic [13:0]     count;
    logic [13:0]     snap;
    logic            pending;
    logic            tick;
    logic            frame_take;

    assign tick       = running && (tick_cnt == TICK_LAST);
    assign frame_take = (state == IDLE) && pending;
    assign o_count    = count;
    assign o_running  = running;

    // pending comes out of reset set so the remote display is forced to 0000.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running  <= 1'b0;
            tick_cnt <= '0;
            count    <= '0;
            pending  <= 1'b1;
            snap     <= '0;
        end else begin
            if (i_run_stop) begin
                running <= !running;
            end

            if (i_clear) begin
                tick_cnt <= '0;
            end else if (running) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end

            if (i_clear) begin
                count <= '0;
            end else if (tick) begin
                count <= (count == CNT_LAST) ? 14'd0 : count + 14'd1;
            end

            // A new event on the same edge a frame launches re-arms pending.
            if (i_clear || tick) begin
                pending <= 1'b1;
            end else if (frame_take) begin
                pending <= 1'b0;
            end

            if (frame_take) begin
                snap <= count;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_start   = 1'b0;
        o_tx_data = 8'h00;
        o_ss_n    = 1'b0;
        case (state)
            IDLE: begin
                o_ss_n = 1'b1;
                if (pending) begin
                    state_nxt = SS_SETUP;
                end
            end
            SS_SETUP: begin
                state_nxt = SEND_HI;
            end
            SEND_HI: begin
                o_start   = 1'b1;
                o_tx_data = {2'b00, snap[13:8]};
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                o_tx_data = {2'b00, snap[13:8]};
                if (i_done) begin
                    state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                o_start   = 1'b1;
                o_tx_data = snap[7:0];
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                o_tx_data = snap[7:0];
                if (i_done) begin
                    state_nxt = SS_HOLD;
                end
            end
            SS_HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                o_ss_n    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
